dbg_ctrl: RTL and testbench
===========================

Name: dbg_ctrl

Overview:
- Host-to-core debug controller: the inbound counterpart of the core's outbound debug event reporting.
- Accepts commands from the simulator/host debugger over a valid/ready command channel: halt, resume, single-step, GPR read/write, PC read.
- Drives core halt/step control and a register-file debug port, and returns one response per command over a valid/ready response channel.
- Sits between the host bridge and the core top; also auto-halts the core on a retired ebreak.

Parameters:
XLEN, 32, data/PC width
NREG, 16, number of architectural GPRs (RV32E); register index width is 5 bits regardless

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  controller accepts command
cmd_op  in  3  0 STATUS, 1 HALT, 2 RESUME, 3 STEP, 4 READ_GPR, 5 WRITE_GPR, 6 READ_PC, 7 reserved
cmd_addr  in  5  GPR index
cmd_data  in  XLEN  GPR write data
rsp_valid  out  1  response valid
rsp_ready  in  1  host takes response
rsp_data  out  XLEN  response payload
rsp_err  out  1  command rejected
core_halt_req  out  1  1 = core must not issue new instructions
core_halted  in  1  core drained (no instruction in flight) while halt_req=1
core_retire  in  1  one instruction retired this cycle
core_is_ebreak  in  1  retiring instruction is ebreak (qualified by core_retire)
core_pc  in  XLEN  architectural PC of next instruction
rf_en  out  1  regfile debug access strobe
rf_we  out  1  regfile debug write
rf_addr  out  5  regfile debug index
rf_wdata  out  XLEN  regfile debug write data
rf_rdata  in  XLEN  regfile read data, valid one cycle after rf_en
halted  out  1  status: core stopped under debug control

Behaviour:
- Reset: state RUN. All outputs 0: core_halt_req, halted, cmd_ready, rsp_valid, rsp_err, rsp_data, rf_*.
- Reset mid-operation abandons any in-flight command and pending response; no response is produced for it.
- States: RUN, HALT_WAIT, HALTED, STEP_ISSUE, STEP_WAIT, RF_ACC, RESP. All outputs are registered-state decodes; there are no combinational input-to-output paths.
- cmd_ready = 1 only in RUN or HALTED. A command is accepted on cmd_valid & cmd_ready; op/addr/data are latched on acceptance.
- core_halt_req = 1 in every state except RUN and STEP_ISSUE.
- halted = 1 in HALTED, RF_ACC, and in RESP when the return state is HALTED.
- RUN + HALT: go to HALT_WAIT. On core_halted=1, go to HALTED and load response {data=core_pc, err=0}.
- RUN + retired ebreak (core_retire & core_is_ebreak): go to HALT_WAIT with no response. If a command is accepted in the same cycle, the ebreak takes priority; the command is processed after reaching HALTED.
- RUN + STEP / READ_GPR / WRITE_GPR / READ_PC: rsp err=1, data=0.
- RUN + RESUME: rsp err=0, no-op.
- STATUS (any accepting state): rsp data={31'b0, halted}, err=0.
- HALTED + HALT: immediate rsp {core_pc, 0}.
- HALTED + RESUME: rsp err=0. After rsp_ready, return to RUN; core_halt_req drops in the cycle after the handshake.
- HALTED + STEP:
  - STEP_ISSUE holds core_halt_req=0 for exactly 1 cycle.
  - Then STEP_WAIT (halt_req=1) until a core_retire has been seen and core_halted=1.
  - Response {core_pc, 0}; return to HALTED.
  - An ebreak retired during the step has no extra effect.
- HALTED + READ_GPR:
  - RF_ACC: rf_en=1, rf_addr=addr for 1 cycle.
  - Next cycle, rf_rdata is captured into rsp_data.
  - rsp_valid rises 2 cycles after acceptance.
- HALTED + WRITE_GPR: rf_en=rf_we=1 for 1 cycle; rsp err=0 the next cycle.
  - addr=0: rf_we stays 0 (x0 immutable); response err=0.
- addr >= NREG on READ_GPR/WRITE_GPR: no regfile access; rsp err=1, data=0.
- HALTED + READ_PC: rsp {core_pc, 0}.
- op 7: rsp err=1, data=0.
- RESP: rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready. Leave RESP the same cycle rsp_ready is sampled; return to RUN or HALTED.
- Exactly one response per accepted command. No command is accepted while a response is pending.
- rf_en/rf_we are asserted only in RF_ACC, never while the core runs.

Test Plan:
- Reset asserted mid READ_GPR, then released -> rsp_valid never rises for that command; state RUN; core_halt_req=0; cmd_ready=1 next cycle.
- RUN, HALT with core_halted rising 3 cycles later, core_pc=0x80000010 -> rsp {0x80000010, err 0}; halted=1; core_halt_req stays 1.
- HALTED; WRITE_GPR addr 5 data 0xDEADBEEF, then READ_GPR 5 -> rf_we pulse at addr 5; read rsp 0xDEADBEEF 2 cycles after acceptance. WRITE_GPR addr 0 -> rf_we=0. READ_GPR addr 20 -> err=1.
- HALTED, STEP; core retires 1 instruction, pc 0x80000000 -> 0x80000004 -> core_halt_req low for exactly 1 cycle; rsp {0x80000004, 0}; halted=1.
- RUN, core_retire & core_is_ebreak while cmd STATUS is presented -> HALT_WAIT; after core_halted, STATUS rsp data=1.
- Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid/data stable; cmd_ready=0 throughout. RUN+READ_PC -> err=1.

Source files
------------

// File: rtl/dbg_ctrl.sv
// Host-to-core debug controller.
// Takes halt/resume/step/register/PC commands from the host debugger and returns
// one response for each. It drives core halt/step control and the register-file
// debug port, and auto-halts the core when an ebreak retires.
module dbg_ctrl #(
    parameter int XLEN = 32,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [4:0]      cmd_addr,
    input  logic [XLEN-1:0] cmd_data,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_err,
    output logic            core_halt_req,
    input  logic            core_halted,
    input  logic            core_retire,
    input  logic            core_is_ebreak,
    input  logic [XLEN-1:0] core_pc,
    output logic            rf_en,
    output logic            rf_we,
    output logic [4:0]      rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [XLEN-1:0] rf_rdata,
    output logic            halted
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALT_WAIT,
        ST_HALTED,
        ST_STEP_ISSUE,
        ST_STEP_WAIT,
        ST_RF_ACC,
        ST_RESP
    } state_t;

    localparam logic [2:0] OP_STATUS    = 3'd0;
    localparam logic [2:0] OP_HALT      = 3'd1;
    localparam logic [2:0] OP_RESUME    = 3'd2;
    localparam logic [2:0] OP_STEP      = 3'd3;
    localparam logic [2:0] OP_READ_GPR  = 3'd4;
    localparam logic [2:0] OP_WRITE_GPR = 3'd5;
    localparam logic [2:0] OP_READ_PC   = 3'd6;

    localparam logic [5:0]      NREG_LIM = 6'(NREG);
    localparam logic [XLEN-1:0] ONE_W    = {{(XLEN-1){1'b0}}, 1'b1};

    state_t            state_reg, state_next;
    logic [2:0]        op_reg, op_next;
    logic [4:0]        addr_reg, addr_next;
    logic [XLEN-1:0]   data_reg, data_next;
    logic [XLEN-1:0]   rsp_data_reg, rsp_data_next;
    logic              rsp_err_reg, rsp_err_next;
    logic              ret_halted_reg, ret_halted_next;  // RESP returns to HALTED
    logic              pend_reg, pend_next;              // command deferred by an ebreak halt
    logic              wait_rsp_reg, wait_rsp_next;      // HALT_WAIT owes a HALT response
    logic              step_seen_reg, step_seen_next;    // a retire was seen during the step
    logic              rf_phase_reg, rf_phase_next;      // 0: access cycle, 1: read capture cycle
    logic              cmd_ready_reg, cmd_ready_next;

    logic              accept;
    logic [2:0]        src_op;
    logic [4:0]        src_addr;
    logic              seen_now;

    assign accept   = cmd_valid && cmd_ready_reg;
    assign src_op   = pend_reg ? op_reg : cmd_op;
    assign src_addr = pend_reg ? addr_reg : cmd_addr;
    assign seen_now = step_seen_reg || core_retire;

    // State and datapath registers; reset drops any in-flight command or response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            op_reg         <= '0;
            addr_reg       <= '0;
            data_reg       <= '0;
            rsp_data_reg   <= '0;
            rsp_err_reg    <= 1'b0;
            ret_halted_reg <= 1'b0;
            pend_reg       <= 1'b0;
            wait_rsp_reg   <= 1'b0;
            step_seen_reg  <= 1'b0;
            rf_phase_reg   <= 1'b0;
            cmd_ready_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_reg         <= op_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_err_reg    <= rsp_err_next;
            ret_halted_reg <= ret_halted_next;
            pend_reg       <= pend_next;
            wait_rsp_reg   <= wait_rsp_next;
            step_seen_reg  <= step_seen_next;
            rf_phase_reg   <= rf_phase_next;
            cmd_ready_reg  <= cmd_ready_next;
        end
    end

    // Next-state logic: command dispatch, halt/step sequencing and response loading.
    always_comb begin
        state_next      = state_reg;
        op_next         = op_reg;
        addr_next       = addr_reg;
        data_next       = data_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_err_next    = rsp_err_reg;
        ret_halted_next = ret_halted_reg;
        pend_next       = pend_reg;
        wait_rsp_next   = wait_rsp_reg;
        step_seen_next  = step_seen_reg;
        rf_phase_next   = rf_phase_reg;

        if (accept) begin
            op_next   = cmd_op;
            addr_next = cmd_addr;
            data_next = cmd_data;
        end

        case (state_reg)
            ST_RUN: begin
                if (core_retire && core_is_ebreak) begin
                    // The ebreak wins; a command taken this cycle runs once halted.
                    state_next    = ST_HALT_WAIT;
                    wait_rsp_next = 1'b0;
                    pend_next     = accept;
                end else if (accept) begin
                    ret_halted_next = 1'b0;
                    rsp_data_next   = '0;
                    rsp_err_next    = 1'b0;
                    state_next      = ST_RESP;
                    case (cmd_op)
                        OP_HALT: begin
                            state_next    = ST_HALT_WAIT;
                            wait_rsp_next = 1'b1;
                        end
                        OP_STATUS, OP_RESUME: rsp_err_next = 1'b0;
                        default:              rsp_err_next = 1'b1;
                    endcase
                end
            end

            ST_HALT_WAIT: begin
                if (core_halted) begin
                    if (wait_rsp_reg) begin
                        state_next      = ST_RESP;
                        ret_halted_next = 1'b1;
                        rsp_data_next   = core_pc;
                        rsp_err_next    = 1'b0;
                        wait_rsp_next   = 1'b0;
                    end else begin
                        state_next = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                if (pend_reg || accept) begin
                    pend_next       = 1'b0;
                    ret_halted_next = 1'b1;
                    rsp_data_next   = '0;
                    rsp_err_next    = 1'b0;
                    state_next      = ST_RESP;
                    case (src_op)
                        OP_STATUS:  rsp_data_next = ONE_W;
                        OP_HALT:    rsp_data_next = core_pc;
                        OP_RESUME:  ret_halted_next = 1'b0;
                        OP_STEP: begin
                            state_next     = ST_STEP_ISSUE;
                            step_seen_next = 1'b0;
                        end
                        OP_READ_GPR, OP_WRITE_GPR: begin
                            if ({1'b0, src_addr} >= NREG_LIM) begin
                                rsp_err_next = 1'b1;
                            end else begin
                                state_next    = ST_RF_ACC;
                                rf_phase_next = 1'b0;
                            end
                        end
                        OP_READ_PC: rsp_data_next = core_pc;
                        default:    rsp_err_next  = 1'b1;
                    endcase
                end
            end

            ST_STEP_ISSUE: begin
                step_seen_next = core_retire;
                state_next     = ST_STEP_WAIT;
            end

            ST_STEP_WAIT: begin
                step_seen_next = seen_now;
                if (seen_now && core_halted) begin
                    state_next      = ST_RESP;
                    ret_halted_next = 1'b1;
                    rsp_data_next   = core_pc;
                    rsp_err_next    = 1'b0;
                end
            end

            ST_RF_ACC: begin
                if (!rf_phase_reg) begin
                    if (op_reg == OP_WRITE_GPR) begin
                        state_next      = ST_RESP;
                        ret_halted_next = 1'b1;
                        rsp_data_next   = '0;
                        rsp_err_next    = 1'b0;
                    end else begin
                        rf_phase_next = 1'b1;
                    end
                end else begin
                    state_next      = ST_RESP;
                    ret_halted_next = 1'b1;
                    rsp_data_next   = rf_rdata;
                    rsp_err_next    = 1'b0;
                    rf_phase_next   = 1'b0;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ret_halted_reg ? ST_HALTED : ST_RUN;
                end
            end

            default: state_next = ST_RUN;
        endcase

        cmd_ready_next = ((state_next == ST_RUN) || (state_next == ST_HALTED)) && !pend_next;
    end

    // Output decodes from registered state only.
    assign cmd_ready     = cmd_ready_reg;
    assign rsp_valid     = (state_reg == ST_RESP);
    assign rsp_data      = rsp_data_reg;
    assign rsp_err       = rsp_err_reg;
    assign core_halt_req = !((state_reg == ST_RUN) || (state_reg == ST_STEP_ISSUE));
    assign halted        = (state_reg == ST_HALTED) || (state_reg == ST_RF_ACC) ||
                           ((state_reg == ST_RESP) && ret_halted_reg);
    assign rf_en         = (state_reg == ST_RF_ACC) && !rf_phase_reg;
    assign rf_we         = rf_en && (op_reg == OP_WRITE_GPR) && (addr_reg != 5'd0);
    assign rf_addr       = rf_en ? addr_reg : 5'd0;
    assign rf_wdata      = rf_we ? data_reg : '0;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed testbench for dbg_ctrl: a linear sequence of host commands against a
// hand-driven core model and a small register-file model.
module tb_dbg_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        core_halt_req;
    logic        core_halted = 1'b0;
    logic        core_retire = 1'b0;
    logic        core_is_ebreak = 1'b0;
    logic [31:0] core_pc = '0;
    logic        rf_en;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata = '0;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int lat;
    logic [31:0] mem [32];
    logic [31:0] held_data;
    logic        held_err;

    dbg_ctrl #(.XLEN(32), .NREG(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_halt_req(core_halt_req), .core_halted(core_halted), .core_retire(core_retire),
        .core_is_ebreak(core_is_ebreak), .core_pc(core_pc),
        .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata), .halted(halted)
    );

    always #5 clk = ~clk;

    // Register-file model: read data appears the cycle after rf_en.
    always @(posedge clk) begin
        if (rf_en) begin
            if (rf_we) mem[rf_addr] <= rf_wdata;
            rf_rdata <= mem[rf_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [4:0] a, input logic [31:0] d);
        int n = 0;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        while (!rsp_valid && l < 50) begin
            tick();
            l++;
        end
        check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
    endtask

    task automatic take();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;

        // Reset state.
        tick(); tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_halt_req", 32'(core_halt_req), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_rf_en", 32'(rf_en), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        reset = 1'b0;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // HALT from RUN; core drains three cycles later.
        core_pc = 32'h8000_0010;
        send_cmd(3'd1, 5'd0, 32'd0);
        check("hw_halt_req", 32'(core_halt_req), 32'd1);
        check("hw_cmd_ready", 32'(cmd_ready), 32'd0);
        tick(); tick();
        check("hw_no_rsp", 32'(rsp_valid), 32'd0);
        core_halted = 1'b1;
        wait_valid(lat);
        check("halt_rsp_data", rsp_data, 32'h8000_0010);
        check("halt_rsp_err", 32'(rsp_err), 32'd0);
        check("halt_rsp_halted", 32'(halted), 32'd1);
        take();
        check("halted_state", 32'(halted), 32'd1);
        check("halted_halt_req", 32'(core_halt_req), 32'd1);

        // GPR write then read back.
        send_cmd(3'd5, 5'd5, 32'hDEAD_BEEF);
        check("wr5_rf_en", 32'(rf_en), 32'd1);
        check("wr5_rf_we", 32'(rf_we), 32'd1);
        check("wr5_rf_addr", 32'(rf_addr), 32'd5);
        check("wr5_rf_wdata", rf_wdata, 32'hDEAD_BEEF);
        wait_valid(lat);
        check("wr5_lat", 32'(lat), 32'd1);
        check("wr5_err", 32'(rsp_err), 32'd0);
        take();
        send_cmd(3'd4, 5'd5, 32'd0);
        check("rd5_rf_en", 32'(rf_en), 32'd1);
        check("rd5_rf_we", 32'(rf_we), 32'd0);
        wait_valid(lat);
        check("rd5_lat", 32'(lat), 32'd2);
        check("rd5_data", rsp_data, 32'hDEAD_BEEF);
        check("rd5_err", 32'(rsp_err), 32'd0);
        take();

        // x0 is immutable.
        send_cmd(3'd5, 5'd0, 32'h1234_5678);
        check("wr0_rf_en", 32'(rf_en), 32'd1);
        check("wr0_rf_we", 32'(rf_we), 32'd0);
        wait_valid(lat);
        check("wr0_err", 32'(rsp_err), 32'd0);
        take();
        send_cmd(3'd4, 5'd0, 32'd0);
        wait_valid(lat);
        check("rd0_data", rsp_data, 32'd0);
        take();

        // Out-of-range index.
        send_cmd(3'd4, 5'd20, 32'd0);
        check("rd20_rf_en", 32'(rf_en), 32'd0);
        wait_valid(lat);
        check("rd20_err", 32'(rsp_err), 32'd1);
        check("rd20_data", rsp_data, 32'd0);
        take();

        // Single step.
        core_pc = 32'h8000_0000;
        send_cmd(3'd3, 5'd0, 32'd0);
        check("step_issue_halt_req", 32'(core_halt_req), 32'd0);
        core_halted = 1'b0;
        tick();
        check("step_wait_halt_req", 32'(core_halt_req), 32'd1);
        core_retire = 1'b1;
        core_pc = 32'h8000_0004;
        tick();
        core_retire = 1'b0;
        check("step_wait_no_rsp", 32'(rsp_valid), 32'd0);
        core_halted = 1'b1;
        wait_valid(lat);
        check("step_rsp_data", rsp_data, 32'h8000_0004);
        check("step_rsp_err", 32'(rsp_err), 32'd0);
        take();
        check("step_halted", 32'(halted), 32'd1);

        // STATUS while halted, then READ_PC.
        send_cmd(3'd0, 5'd0, 32'd0);
        wait_valid(lat);
        check("status_h_data", rsp_data, 32'd1);
        take();
        send_cmd(3'd6, 5'd0, 32'd0);
        wait_valid(lat);
        check("rdpc_h_data", rsp_data, 32'h8000_0004);
        take();

        // RESUME.
        send_cmd(3'd2, 5'd0, 32'd0);
        wait_valid(lat);
        check("resume_err", 32'(rsp_err), 32'd0);
        check("resume_rsp_halt_req", 32'(core_halt_req), 32'd1);
        take();
        core_halted = 1'b0;
        check("run_halt_req", 32'(core_halt_req), 32'd0);
        check("run_halted", 32'(halted), 32'd0);

        // READ_PC in RUN with response backpressure.
        send_cmd(3'd6, 5'd0, 32'd0);
        wait_valid(lat);
        held_data = rsp_data;
        held_err = rsp_err;
        check("rdpc_run_err", 32'(rsp_err), 32'd1);
        check("rdpc_run_data", rsp_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_data", rsp_data, held_data);
            check("bp_err", 32'(rsp_err), 32'(held_err));
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        take();

        // STATUS, RESUME and reserved op while running.
        send_cmd(3'd0, 5'd0, 32'd0);
        wait_valid(lat);
        check("status_r_data", rsp_data, 32'd0);
        take();
        send_cmd(3'd2, 5'd0, 32'd0);
        wait_valid(lat);
        check("resume_r_err", 32'(rsp_err), 32'd0);
        take();
        send_cmd(3'd7, 5'd0, 32'd0);
        wait_valid(lat);
        check("op7_err", 32'(rsp_err), 32'd1);
        take();

        // Ebreak retires while STATUS is presented.
        check("eb_pre_ready", 32'(cmd_ready), 32'd1);
        cmd_op = 3'd0; cmd_valid = 1'b1;
        core_retire = 1'b1; core_is_ebreak = 1'b1;
        tick();
        cmd_valid = 1'b0; core_retire = 1'b0; core_is_ebreak = 1'b0;
        check("eb_halt_req", 32'(core_halt_req), 32'd1);
        check("eb_no_rsp", 32'(rsp_valid), 32'd0);
        check("eb_cmd_ready", 32'(cmd_ready), 32'd0);
        tick(); tick();
        check("eb_still_no_rsp", 32'(rsp_valid), 32'd0);
        core_halted = 1'b1;
        wait_valid(lat);
        check("eb_status_data", rsp_data, 32'd1);
        check("eb_status_err", 32'(rsp_err), 32'd0);
        take();
        check("eb_halted", 32'(halted), 32'd1);

        // Reset mid READ_GPR.
        send_cmd(3'd4, 5'd5, 32'd0);
        check("mid_rf_en", 32'(rf_en), 32'd1);
        reset = 1'b1;
        tick();
        core_halted = 1'b0;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_halt_req", 32'(core_halt_req), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        tick();
        check("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("mid_post_rsp_valid", 32'(rsp_valid), 32'd0);
            check("mid_post_halted", 32'(halted), 32'd0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
